// File: rtl/window_scheduler_if.sv
// Pixel-in / window-out handshake bundle for the window scheduler.
// The master side produces pixels and consumes windows; the slave side is the scheduler.
interface window_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]              cfg_sel;
    logic [DATA_WIDTH-1:0]   pix_data;
    logic                    pix_valid;
    logic                    pix_ready;
    logic [DATA_WIDTH*9-1:0] win_data;
    logic [1:0]              win_cfg;
    logic                    win_last;
    logic                    win_valid;
    logic                    win_ready;
    logic                    frame_done;

    modport master (
        output cfg_sel, pix_data, pix_valid, win_ready,
        input  pix_ready, win_data, win_cfg, win_last, win_valid, frame_done
    );

    modport slave (
        input  cfg_sel, pix_data, pix_valid, win_ready,
        output pix_ready, win_data, win_cfg, win_last, win_valid, frame_done
    );
endinterface

// File: rtl/window_scheduler.sv
// Raster-to-window sequencer: buffers two lines and emits every interior 3x3 window
// with a per-frame filter select and end-of-frame markers.
module window_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    window_scheduler_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [1:0]              frame_cfg;
    logic [DATA_WIDTH-1:0]   lb0 [IMG_W];
    logic [DATA_WIDTH-1:0]   lb1 [IMG_W];
    logic [DATA_WIDTH-1:0]   taps [3][2];
    logic [DATA_WIDTH*9-1:0] win_next;
    logic                    accept;
    logic                    produce;
    logic                    col_last;
    logic                    row_last;
    logic                    win_hs;

    assign bus.pix_ready = (state == IDLE) ||
                           (((state == FILL) || (state == STREAM)) &&
                            (!bus.win_valid || bus.win_ready));
    assign accept   = bus.pix_valid && bus.pix_ready;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign produce  = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign win_hs   = bus.win_valid && bus.win_ready;

    // The incoming column (lb1, lb0, pixel) is the third window column, so only two are stored
    assign win_next = {bus.pix_data, taps[2][1], taps[2][0],
                       lb0[col],     taps[1][1], taps[1][0],
                       lb1[col],     taps[0][1], taps[0][0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FILL;
            FILL:    if (accept && (row == RW'(1)) && col_last) state_nxt = STREAM;
            STREAM:  if (accept && row_last && col_last) state_nxt = DRAIN;
            DRAIN:   if (win_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            frame_cfg <= '0;
        end else if (accept) begin
            if (state == IDLE) frame_cfg <= bus.cfg_sel;
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers and window taps hold only pixel history, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.pix_data;
            for (int i = 0; i < 3; i++) taps[i][0] <= taps[i][1];
            taps[0][1] <= lb1[col];
            taps[1][1] <= lb0[col];
            taps[2][1] <= bus.pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.win_valid  <= 1'b0;
            bus.win_data   <= '0;
            bus.win_cfg    <= '0;
            bus.win_last   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= (state == DRAIN) && win_hs;
            if (produce) begin
                bus.win_valid <= 1'b1;
                bus.win_data  <= win_next;
                bus.win_cfg   <= frame_cfg;
                bus.win_last  <= row_last && col_last;
            end else if (bus.win_ready) begin
                bus.win_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window_scheduler.sv
// Directed and randomised-handshake bench for window_scheduler on a 4x4 frame
// with pixel value r*4+c and a queue of expected windows.
module tb_window_scheduler;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef logic [71:0] val_t;
    typedef struct {
        logic [9*DW-1:0] data;
        logic [1:0]      cfg;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    window_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    window_scheduler #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fails    = 0;
    int   win_cnt    = 0;
    int   done_cnt   = 0;
    bit   rand_ready = 1'b0;
    bit   rand_gaps  = 1'b0;
    bit   prev_last  = 1'b0;

    task automatic checkOutput(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference window straight from the raster coordinates of the producing pixel
    function automatic logic [9*DW-1:0] modelWin(input int r, input int c);
        logic [9*DW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[DW*k +: DW] = DW'((r - 2 + k / 3) * W + (c - 2 + k % 3));
        return v;
    endfunction

    task automatic applyStimulus(input int r, input int c, input logic [1:0] fcfg);
        int   t;
        exp_t e;
        t = 0;
        if (rand_gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = DW'(r * W + c);
        @(negedge clk);
        while (!bus.pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) checkOutput("pix_ready_timeout", val_t'(0), val_t'(1));
        if (r >= 2 && c >= 2) begin
            e.data = modelWin(r, c);
            e.cfg  = fcfg;
            e.last = (r == H - 1) && (c == W - 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [1:0] fcfg, input int change_at, input logic [1:0] new_cfg);
        bus.cfg_sel = fcfg;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c == change_at) bus.cfg_sel = new_cfg;
                applyStimulus(r, c, fcfg);
            end
        end
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) checkOutput("drain_timeout", val_t'(sb.size()), val_t'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.cfg_sel   = '0;
        bus.win_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_last = 1'b0;
                end else begin
                    if (bus.frame_done || prev_last)
                        checkOutput("frame_done", val_t'(bus.frame_done), val_t'(prev_last));
                    if (bus.frame_done) done_cnt++;
                    prev_last = 1'b0;
                    if (bus.win_valid && bus.win_ready) begin
                        win_cnt++;
                        if (sb.size() == 0) begin
                            checkOutput("unexpected_window", val_t'(bus.win_data), val_t'(0));
                        end else begin
                            mon_e = sb.pop_front();
                            checkOutput("win_data", val_t'(bus.win_data), val_t'(mon_e.data));
                            checkOutput("win_cfg",  val_t'(bus.win_cfg),  val_t'(mon_e.cfg));
                            checkOutput("win_last", val_t'(bus.win_last), val_t'(mon_e.last));
                            prev_last = bus.win_last;
                        end
                    end
                end
            end
            forever begin
                @(posedge clk);
                #1;
                if (rand_ready) bus.win_ready = 1'($urandom_range(0, 1));
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_win_valid",  val_t'(bus.win_valid),  val_t'(0));
        checkOutput("rst_win_data",   val_t'(bus.win_data),   val_t'(0));
        checkOutput("rst_win_cfg",    val_t'(bus.win_cfg),    val_t'(0));
        checkOutput("rst_win_last",   val_t'(bus.win_last),   val_t'(0));
        checkOutput("rst_frame_done", val_t'(bus.frame_done), val_t'(0));
        checkOutput("rst_pix_ready",  val_t'(bus.pix_ready),  val_t'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] streaming frame");
        win_cnt = 0; done_cnt = 0;
        sendFrame(2'd2, -1, 2'd0);
        waitDrain();
        checkOutput("stream_windows", val_t'(win_cnt), val_t'(4));
        checkOutput("stream_done",    val_t'(done_cnt), val_t'(1));

        $display("[TB] backpressure");
        win_cnt = 0; done_cnt = 0;
        bus.cfg_sel = 2'd0;
        for (int i = 0; i <= 10; i++) applyStimulus(i / W, i % W, 2'd0);
        bus.win_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_win_valid", val_t'(bus.win_valid), val_t'(1));
            checkOutput("bp_pix_ready", val_t'(bus.pix_ready), val_t'(0));
            checkOutput("bp_win_data",  val_t'(bus.win_data),  val_t'(modelWin(2, 2)));
        end
        @(posedge clk);
        #1;
        bus.win_ready = 1'b1;
        for (int i = 11; i < W * H; i++) applyStimulus(i / W, i % W, 2'd0);
        waitDrain();
        checkOutput("bp_windows", val_t'(win_cnt), val_t'(4));
        checkOutput("bp_done",    val_t'(done_cnt), val_t'(1));

        $display("[TB] config latch");
        win_cnt = 0; done_cnt = 0;
        sendFrame(2'd1, 5, 2'd3);
        waitDrain();
        sendFrame(2'd3, -1, 2'd0);
        waitDrain();
        checkOutput("cfg_windows", val_t'(win_cnt), val_t'(8));
        checkOutput("cfg_done",    val_t'(done_cnt), val_t'(2));

        $display("[TB] reset mid-frame");
        win_cnt = 0; done_cnt = 0;
        bus.cfg_sel = 2'd0;
        for (int i = 0; i <= 9; i++) applyStimulus(i / W, i % W, 2'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_win_valid",  val_t'(bus.win_valid),  val_t'(0));
        checkOutput("midrst_frame_done", val_t'(bus.frame_done), val_t'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sendFrame(2'd2, -1, 2'd0);
        waitDrain();
        checkOutput("midrst_windows", val_t'(win_cnt), val_t'(4));
        checkOutput("midrst_done",    val_t'(done_cnt), val_t'(1));

        $display("[TB] back-to-back frames with random gaps");
        win_cnt = 0; done_cnt = 0;
        rand_ready = 1'b1;
        rand_gaps  = 1'b1;
        sendFrame(2'd1, -1, 2'd0);
        sendFrame(2'd2, -1, 2'd0);
        rand_gaps = 1'b0;
        waitDrain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.win_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("b2b_windows", val_t'(win_cnt), val_t'(8));
        checkOutput("b2b_done",    val_t'(done_cnt), val_t'(2));
        checkOutput("b2b_sb_empty", val_t'(sb.size()), val_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
